// File: rtl/mux81_scan_pkg.sv
// mux81_scan_pkg: shared state encoding and channel geometry for the mux81 scan sequencer
package mux81_scan_pkg;
    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;
endpackage

// File: rtl/mux81_scan_ctrl_if.sv
// mux81_scan_ctrl_if: scan request, mux select/data and result bus between sequencer and its user
interface mux81_scan_ctrl_if;
    import mux81_scan_pkg::*;
    logic              start;
    logic [NUM_CH-1:0] mask;
    logic              o_in;
    logic              s2;
    logic              s1;
    logic              s0;
    logic              busy;
    logic              done;
    logic [NUM_CH-1:0] sample;
    logic              parity;
    modport master (output start, mask, o_in, input s2, s1, s0, busy, done, sample, parity);
    modport slave  (input start, mask, o_in, output s2, s1, s0, busy, done, sample, parity);
endinterface

// File: rtl/mux81.sv
// mux81: plain 8:1 multiplexer, channel a..h selected by {s2,s1,s0}
module mux81 (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    input  logic e,
    input  logic f,
    input  logic g,
    input  logic h,
    input  logic s2,
    input  logic s1,
    input  logic s0,
    output logic o
);
    logic [7:0] v;
    assign v = {h, g, f, e, d, c, b, a};
    assign o = v[{s2, s1, s0}];
endmodule

// File: rtl/mux81_next_ch.sv
// mux81_next_ch: lowest enabled channel in mask_q, either overall or strictly above cur
module mux81_next_ch
    import mux81_scan_pkg::*;
(
    input  logic [NUM_CH-1:0] mask_q,
    input  logic [SEL_W-1:0]  cur,
    input  logic              from_start,
    output logic [SEL_W-1:0]  nxt,
    output logic              vld
);
    // descending walk so the lowest qualifying channel is the last one written
    always_comb begin
        nxt = '0;
        vld = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_q[i] && (from_start || SEL_W'(i) > cur)) begin
                nxt = SEL_W'(i);
                vld = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mux81_scan_ctrl.sv
// mux81_scan_ctrl: steps mux81 selects over masked channels, dwells, captures o, reports the word
// Optional parity output enabled by defining MUX81_SCAN_PARITY_EN.
module mux81_scan_ctrl
    import mux81_scan_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    mux81_scan_ctrl_if.slave    bus
);
    localparam logic [CNT_W-1:0] DWELL_M1 = CNT_W'(DWELL - 1);

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  ch_q, ch_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [NUM_CH-1:0] shadow_q, shadow_d;
    logic [NUM_CH-1:0] sample_q, sample_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [SEL_W-1:0]  nxt_ch;
    logic              nxt_vld;
    logic              idle;

    assign idle = (state_q == IDLE);

    // in IDLE the search runs on the live mask so the first channel is known at the start edge
    mux81_next_ch u_next (
        .mask_q     (idle ? bus.mask : mask_q),
        .cur        (ch_q),
        .from_start (idle),
        .nxt        (nxt_ch),
        .vld        (nxt_vld)
    );

    // next-state: sequencing, capture into shadow, and result publish on DONE entry
    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        cnt_d    = cnt_q;
        mask_d   = mask_q;
        shadow_d = shadow_q;
        sample_d = sample_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mask_d   = bus.mask;
                    shadow_d = '0;
                    if (nxt_vld) begin
                        ch_d    = nxt_ch;
                        cnt_d   = DWELL_M1;
                        state_d = SETTLE;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SETTLE: begin
                if (cnt_q == '0) state_d = CAPTURE;
                else cnt_d = cnt_q - CNT_W'(1);
            end
            CAPTURE: begin
                shadow_d[ch_q] = bus.o_in;
                if (nxt_vld) begin
                    ch_d    = nxt_ch;
                    cnt_d   = DWELL_M1;
                    state_d = SETTLE;
                end else begin
                    ch_d    = '0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d == DONE) sample_d = shadow_d;
        busy_d = (state_d == SETTLE) || (state_d == CAPTURE);
        done_d = (state_d == DONE);
    end

    // state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ch_q     <= '0;
            cnt_q    <= '0;
            mask_q   <= '0;
            shadow_q <= '0;
            sample_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            shadow_q <= shadow_d;
            sample_q <= sample_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

`ifdef MUX81_SCAN_PARITY_EN
    logic parity_q, parity_d;
    assign parity_d = (state_d == DONE) ? ^shadow_d : parity_q;
    // parity registered alongside sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) parity_q <= 1'b0;
        else parity_q <= parity_d;
    end
    assign bus.parity = parity_q;
`else
    assign bus.parity = 1'b0;
`endif

    assign {bus.s2, bus.s1, bus.s0} = ch_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.sample = sample_q;
endmodule

// File: tb/tb_mux81_scan_ctrl.sv
// tb_mux81_scan_ctrl: directed scenarios for the mux81 scan sequencer with DWELL=2
module tb_mux81_scan_ctrl;
    logic clk;
    logic rst_n;
    logic [7:0] chv;
    mux81_scan_ctrl_if bus ();

    int n_chk;
    int n_err;
    logic [2:0] sel_tr [0:40];
    int done_at;
    int n_done;
    bit busy_seen;
    logic exp_par;

    mux81 u_mux (
        .a(chv[0]), .b(chv[1]), .c(chv[2]), .d(chv[3]),
        .e(chv[4]), .f(chv[5]), .g(chv[6]), .h(chv[7]),
        .s2(bus.s2), .s1(bus.s1), .s0(bus.s0), .o(bus.o_in)
    );

    mux81_scan_ctrl #(.DWELL(2), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // pulse start with mask m, then record 41 cycles (cycle 0 = just after E0)
    task automatic run_scan(input logic [7:0] m, input int poke);
        @(negedge clk);
        bus.start = 1'b1;
        bus.mask  = m;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        done_at   = -1;
        n_done    = 0;
        busy_seen = 1'b0;
        for (int k = 0; k <= 40; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            sel_tr[k] = {bus.s2, bus.s1, bus.s0};
            if (bus.busy) busy_seen = 1'b1;
            if (bus.done) begin
                n_done++;
                if (done_at < 0) done_at = k;
            end
            if (k == poke) begin
                bus.start = 1'b1;
                bus.mask  = 8'h01;
            end else if (k == poke + 1) begin
                bus.start = 1'b0;
            end
        end
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        chv = 8'hAA;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.mask = 8'hFF;
`ifdef MUX81_SCAN_PARITY_EN
        exp_par = 1'b1;
`else
        exp_par = 1'b0;
`endif
        #12;
        chk("rst_sel", {bus.s2, bus.s1, bus.s0}, 3'd0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_sample", bus.sample, 8'h00);
        chk("rst_parity", bus.parity, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        run_scan(8'hFF, -10);
        chk("full_done_at", done_at, 24);
        chk("full_n_done", n_done, 1);
        chk("full_sample", bus.sample, 8'hAA);
        chk("full_parity", bus.parity, 1'b0);
        chk("full_sel0", sel_tr[0], 3'd0);
        chk("full_sel2", sel_tr[2], 3'd0);
        chk("full_sel3", sel_tr[3], 3'd1);
        chk("full_sel14", sel_tr[14], 3'd4);
        chk("full_sel23", sel_tr[23], 3'd7);
        chk("full_sel24", sel_tr[24], 3'd0);
        chk("full_busy", busy_seen, 1'b1);

        run_scan(8'h81, -10);
        chk("sparse_done_at", done_at, 6);
        chk("sparse_sample", bus.sample, 8'h80);
        chk("sparse_sel2", sel_tr[2], 3'd0);
        chk("sparse_sel3", sel_tr[3], 3'd7);
        chk("sparse_sel5", sel_tr[5], 3'd7);

        run_scan(8'h00, -10);
        chk("empty_done_at", done_at, 0);
        chk("empty_n_done", n_done, 1);
        chk("empty_sample", bus.sample, 8'h00);
        chk("empty_busy", busy_seen, 1'b0);
        chk("empty_sel0", sel_tr[0], 3'd0);

        run_scan(8'hFF, 5);
        chk("ign_done_at", done_at, 24);
        chk("ign_n_done", n_done, 1);
        chk("ign_sample", bus.sample, 8'hAA);
        chk("ign_sel23", sel_tr[23], 3'd7);

        @(negedge clk);
        bus.start = 1'b1;
        bus.mask  = 8'hFF;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("mid_busy_pre", bus.busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_sel", {bus.s2, bus.s1, bus.s0}, 3'd0);
        chk("mid_busy", bus.busy, 1'b0);
        chk("mid_done", bus.done, 1'b0);
        chk("mid_sample", bus.sample, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        run_scan(8'hFF, -10);
        chk("post_done_at", done_at, 24);
        chk("post_sample", bus.sample, 8'hAA);

        run_scan(8'h02, -10);
        chk("par_done_at", done_at, 3);
        chk("par_sample", bus.sample, 8'h02);
        chk("par_parity", bus.parity, exp_par);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
